// File: rtl/csi_rx_lane_deskew.sv
// CSI-2 RX lane deskew: per-lane delay lines, taps locked on the first
// all-lane-valid word and held until packet_done.
module csi_rx_lane_deskew #(
  parameter int NUM_LANE = 2,
  parameter int MAX_SKEW = 2,
  localparam int TAP_W = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1
) (
  input  logic                      byte_clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      packet_done,
  input  logic                      wait_for_sync,
  input  logic [NUM_LANE*8-1:0]     byte_in,
  input  logic [NUM_LANE-1:0]       valid_in,
  output logic                      packet_done_out,
  output logic [NUM_LANE*8-1:0]     word_out,
  output logic                      valid_out,
  output logic                      locked,
  output logic [NUM_LANE*TAP_W-1:0] taps_out,
  output logic                      skew_err
);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [MAX_SKEW:0][NUM_LANE*8-1:0] byte_q, byte_d;
  logic [MAX_SKEW:0][NUM_LANE-1:0]   vld_q, vld_d;

  logic [NUM_LANE*TAP_W-1:0] taps_q, taps_d;
  logic [NUM_LANE*8-1:0]     word_q, word_d;
  logic                      valid_q, valid_d;
  logic                      skew_q, skew_d;

  logic [NUM_LANE*TAP_W-1:0] tap_new;
  logic [NUM_LANE-1:0]       full_lane;
  logic                      lock_ok;
  logic                      skew_cond;

  // Tap = run of valids behind stage 0; a lane saturating the whole line
  // while another lane is still idle means skew beyond MAX_SKEW.
  always_comb begin
    logic             run;
    logic [TAP_W-1:0] cnt;
    tap_new   = '0;
    full_lane = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      run = 1'b1;
      cnt = '0;
      for (int k = 1; k <= MAX_SKEW; k++) begin
        run = run & vld_q[k][i];
        cnt = cnt + TAP_W'(run);
      end
      tap_new[i*TAP_W +: TAP_W] = cnt;
      full_lane[i] = 1'b1;
      for (int k = 0; k <= MAX_SKEW; k++) begin
        full_lane[i] = full_lane[i] & vld_q[k][i];
      end
    end
  end

  assign lock_ok   = &vld_q[0];
  assign skew_cond = (MAX_SKEW > 0) && (state_q == SEARCH) &&
                     !lock_ok && (|full_lane);

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    vld_d   = vld_q;
    taps_d  = taps_q;
    word_d  = word_q;
    valid_d = valid_q;
    skew_d  = skew_q;
    if (enable) begin
      byte_d[0] = byte_in;
      vld_d[0]  = valid_in;
      for (int k = 1; k <= MAX_SKEW; k++) begin
        byte_d[k] = byte_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      for (int i = 0; i < NUM_LANE; i++) begin
        word_d[i*8 +: 8] = byte_q[taps_q[i*TAP_W +: TAP_W]][i*8 +: 8];
      end
      valid_d = (state_q == LOCKED);
      skew_d  = skew_cond;
      unique case (state_q)
        SEARCH: begin
          if (lock_ok && wait_for_sync) begin
            state_d = LOCKED;
            taps_d  = tap_new;
          end
        end
        LOCKED: begin
          if (packet_done) begin
            state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge byte_clock or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      byte_q  <= '0;
      vld_q   <= '0;
      taps_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      skew_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      taps_q  <= taps_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      skew_q  <= skew_d;
    end
  end

  assign packet_done_out = packet_done | (enable & skew_cond);
  assign word_out        = word_q;
  assign valid_out       = valid_q;
  assign locked          = (state_q == LOCKED);
  assign taps_out        = taps_q;
  assign skew_err        = skew_q;

endmodule

// File: tb/tb_csi_rx_lane_deskew.sv
// Randomised scoreboard bench for csi_rx_lane_deskew (4 lanes, skew 3)
// against a history-based reference model.
module tb_csi_rx_lane_deskew;

  localparam int NL = 4;
  localparam int MS = 3;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic packet_done;
  logic wait_for_sync;
  logic [NL*8-1:0] byte_in;
  logic [NL-1:0]   valid_in;
  logic            packet_done_out;
  logic [NL*8-1:0] word_out;
  logic            valid_out;
  logic            locked;
  logic [NL*TW-1:0] taps_out;
  logic            skew_err;

  csi_rx_lane_deskew #(
    .NUM_LANE(NL),
    .MAX_SKEW(MS)
  ) dut (
    .byte_clock     (clk),
    .reset          (rst),
    .enable         (enable),
    .packet_done    (packet_done),
    .wait_for_sync  (wait_for_sync),
    .byte_in        (byte_in),
    .valid_in       (valid_in),
    .packet_done_out(packet_done_out),
    .word_out       (word_out),
    .valid_out      (valid_out),
    .locked         (locked),
    .taps_out       (taps_out),
    .skew_err       (skew_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: input history, newest first (hist[k] = stage k)
  typedef struct packed {
    logic [NL-1:0]   v;
    logic [NL*8-1:0] b;
  } samp_t;

  samp_t           hist[$];
  logic [NL*8-1:0] sb_q[$];
  logic            m_locked;
  int              m_tap[NL];
  logic [NL*8-1:0] m_word;
  logic            m_vout;
  logic            m_skerr;
  logic            en_last;

  task automatic model_reset();
    samp_t z;
    z = '0;
    hist.delete();
    for (int k = 0; k <= MS; k++) hist.push_back(z);
    sb_q.delete();
    m_locked = 1'b0;
    for (int i = 0; i < NL; i++) m_tap[i] = 0;
    m_word  = '0;
    m_vout  = 1'b0;
    m_skerr = 1'b0;
    en_last = 1'b0;
  endtask

  function automatic int run_len(int lane);
    int n;
    n = 0;
    for (int k = 1; k <= MS; k++) begin
      if (!hist[k].v[lane]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic skew_now();
    logic all;
    if (m_locked || (&hist[0].v)) return 1'b0;
    for (int i = 0; i < NL; i++) begin
      all = 1'b1;
      for (int k = 0; k <= MS; k++) if (!hist[k].v[i]) all = 1'b0;
      if (all) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic            lok;
    logic            sk;
    logic            nv;
    logic [NL*8-1:0] w;
    samp_t           s;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        en_last = enable;
        if (enable) begin
          lok = &hist[0].v;
          sk  = skew_now();
          for (int i = 0; i < NL; i++) w[8*i +: 8] = hist[m_tap[i]].b[8*i +: 8];
          nv = m_locked;
          if (!m_locked && lok && wait_for_sync) begin
            m_locked = 1'b1;
            for (int i = 0; i < NL; i++) m_tap[i] = run_len(i);
          end else if (m_locked && packet_done) begin
            m_locked = 1'b0;
          end
          m_word  = w;
          m_vout  = nv;
          m_skerr = sk;
          if (nv) sb_q.push_back(w);
          s.v = valid_in;
          s.b = byte_in;
          hist.push_front(s);
          void'(hist.pop_back());
        end
      end
    end
  end

  // Monitor
  logic            prev_vout;
  logic [NL*8-1:0] first_word;

  initial begin
    logic [NL*TW-1:0] et;
    logic [NL*8-1:0]  w;
    prev_vout  = 1'b0;
    first_word = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_vout = 1'b0;
      end else begin
        for (int i = 0; i < NL; i++) et[i*TW +: TW] = m_tap[i][TW-1:0];
        chk("locked", locked, m_locked);
        chk("valid_out", valid_out, m_vout);
        chk("taps_out", taps_out, et);
        chk("skew_err", skew_err, m_skerr);
        chk("word_reg", word_out, m_word);
        chk("packet_done_out", packet_done_out,
            packet_done | (enable & skew_now()));
        if (en_last && valid_out) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_word: got %0h expected none at %0t",
                     word_out, $time);
          end else begin
            w = sb_q.pop_front();
            chk("sb_word", word_out, w);
          end
        end
        if (valid_out && !prev_vout) first_word = word_out;
        prev_vout = valid_out;
      end
    end
  end

  task automatic drive(input logic [NL-1:0] v, input logic [NL*8-1:0] b,
                       input logic pd, input logic en);
    @(negedge clk);
    valid_in    = v;
    byte_in     = b;
    packet_done = pd;
    enable      = en;
  endtask

  task automatic send_packet(input int off[NL], input int len,
                             input logic [7:0] base, input int stride,
                             input int pd_at, input int gap_at,
                             input int rst_at, input bit rnd_gap);
    int              maxo;
    int              gl;
    logic [NL-1:0]   v;
    logic [NL*8-1:0] b;
    maxo = 0;
    for (int i = 0; i < NL; i++) if (off[i] > maxo) maxo = off[i];
    for (int c = 0; c < maxo + len; c++) begin
      v = '0;
      b = '0;
      for (int i = 0; i < NL; i++) begin
        if (c >= off[i] && c < off[i] + len) begin
          v[i] = 1'b1;
          b[8*i +: 8] = base + 8'(c - off[i]) + 8'(stride * i);
        end
      end
      if (c == gap_at) begin
        for (int g = 0; g < 5; g++) begin
          drive(v, b, 1'b0, 1'b0);
          #2 chk("gap_locked", locked, 1);
        end
      end else if (rnd_gap && $urandom_range(9, 0) == 0) begin
        gl = $urandom_range(3, 1);
        for (int g = 0; g < gl; g++) drive(v, b, 1'b0, 1'b0);
      end
      drive(v, b, c == pd_at, 1'b1);
      if (rst) rst = 1'b0;
      if (c == rst_at) begin
        #1 chk("pre_rst_locked", locked, 1);
        rst = 1'b1;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_word_out", word_out, 0);
      end
    end
    drive('0, '0, 1'b1, 1'b1);
    repeat (MS + 2) drive('0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int              o[NL];
    logic [7:0]      base;
    logic [NL*8-1:0] ew;
    rst           = 1'b1;
    enable        = 1'b1;
    packet_done   = 1'b0;
    wait_for_sync = 1'b1;
    byte_in       = '0;
    valid_in      = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_locked", locked, 0);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_word_out", word_out, 0);
    chk("reset_taps", taps_out, 0);
    chk("reset_skew_err", skew_err, 0);
    chk("reset_pdo", packet_done_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) drive('0, '0, 1'b0, 1'b1);

    // Lanes valid at offsets 3/0/1/2
    o = '{3, 0, 1, 2};
    send_packet(o, 8, 8'hB7, 0, -1, -1, -1, 1'b0);
    chk("t1_taps", taps_out, 8'h6C);
    chk("t1_first_word", first_word, 32'hB8B8B8B8);
    chk("t1_unlocked", locked, 0);

    // Zero skew
    o = '{0, 0, 0, 0};
    base = 8'($urandom);
    send_packet(o, 6, base, 16, -1, -1, -1, 1'b0);
    for (int i = 0; i < NL; i++) ew[8*i +: 8] = base + 8'd1 + 8'(16 * i);
    chk("t2_taps", taps_out, 0);
    chk("t2_first_word", first_word, ew);

    // Lane 0 leads by more than MAX_SKEW; aligners resync on packet_done_out
    for (int c = 0; c < 4; c++) drive(4'b0001, 32'($urandom), 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b1);
    #2;
    chk("t3_pdo", packet_done_out, 1);
    chk("t3_skew_pre", skew_err, 0);
    drive('0, '0, 1'b0, 1'b1);
    #2;
    chk("t3_skew_err", skew_err, 1);
    chk("t3_pdo_off", packet_done_out, 0);
    drive('0, '0, 1'b0, 1'b1);
    #2;
    chk("t3_skew_end", skew_err, 0);
    chk("t3_locked", locked, 0);
    chk("t3_valid_out", valid_out, 0);
    repeat (3) drive('0, '0, 1'b0, 1'b1);

    // Lock, packet_done, relock with new skew
    o = '{0, 0, 0, 0};
    send_packet(o, 5, 8'($urandom), 16, -1, -1, -1, 1'b0);
    o = '{0, 2, 2, 2};
    send_packet(o, 6, 8'($urandom), 16, -1, -1, -1, 1'b0);
    chk("t4_taps", taps_out, 8'h02);

    // Lock beats coincident packet_done; enable gap mid-packet
    o = '{0, 0, 0, 0};
    send_packet(o, 9, 8'($urandom), 16, 1, 4, -1, 1'b0);
    chk("t5_taps", taps_out, 0);

    // Reset while locked, then relock
    o = '{0, 0, 0, 0};
    send_packet(o, 12, 8'($urandom), 16, -1, -1, 5, 1'b0);
    chk("t6_taps", taps_out, 0);

    // Random packets
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < NL; i++) o[i] = $urandom_range(MS, 0);
      if ($urandom_range(5, 0) == 0) o[$urandom_range(NL - 1, 0)] = 4 + $urandom_range(1, 0);
      wait_for_sync = ($urandom_range(6, 0) != 0);
      send_packet(o, $urandom_range(10, 3), 8'($urandom), 16,
                  -1, -1, -1, 1'b1);
    end
    wait_for_sync = 1'b1;
    repeat (3) drive('0, '0, 1'b0, 1'b1);
    #3;
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
